// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared encodings and sizing constants for the RV32M execute-side units.
//   Contents:
//     RV_XLEN      default datapath width
//     MUL_CNT_W    width of the multiplier bit counter ($clog2 of the width)
//     mulctl_e     multiplier operation select (MUL/MULH/MULHSU/MULHU)
//     mul_state_e  multiplier sequencer states (IDLE/BUSY/FIN)
//     a_is_signed / b_is_signed  operand signedness for a given mulctl
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int unsigned RV_XLEN   = 32;
  localparam int unsigned MUL_CNT_W = $clog2(RV_XLEN);

  typedef enum logic [1:0] {
    MULCTL_MUL    = 2'b00,
    MULCTL_MULH   = 2'b01,
    MULCTL_MULHSU = 2'b10,
    MULCTL_MULHU  = 2'b11
  } mulctl_e;

  typedef enum logic [1:0] {
    MST_IDLE = 2'd0,
    MST_BUSY = 2'd1,
    MST_FIN  = 2'd2
  } mul_state_e;

  // rs1 is signed for everything except MULHU.
  function automatic logic a_is_signed(input mulctl_e ctl);
    return (ctl != MULCTL_MULHU);
  endfunction

  // rs2 is signed only for MUL and MULH.
  function automatic logic b_is_signed(input mulctl_e ctl);
    return (ctl == MULCTL_MUL) || (ctl == MULCTL_MULH);
  endfunction

endpackage

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
//   Iterative RV32M multiplier sitting next to the ALU in the datapath.
//   A request (mulstart + mulctl + operands) is captured in IDLE or FIN; the
//   operand magnitudes are multiplied with a one-bit-per-cycle shift-add loop
//   into a 2*XLEN accumulator, the sign is applied at the end and the low or
//   high half is returned in a register together with a one-cycle exdone.
//
//   Ports:
//     clk       in   1     clock, rising edge
//     rst_n     in   1     asynchronous active-low reset
//     mulstart  in   1     request, only looked at in IDLE or FIN
//     mulctl    in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//     rs1_val   in   XLEN  multiplicand
//     rs2_val   in   XLEN  multiplier
//     result    out  XLEN  selected product half, held until the next FIN
//     exdone    out  1     one-cycle pulse, result valid in the same cycle
//     busy      out  1     high while in BUSY or FIN
//
//   Build option:
//     MUL_EARLY_OUT_EN  when defined, BUSY exits as soon as no set multiplier
//                       bits remain, so latency is 2 + index of the highest
//                       set bit of |b| (2 for b == 0). Results are unchanged.
//                       When undefined, latency is always XLEN+1 cycles.
// -----------------------------------------------------------------------------
module mul_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = RV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mulstart,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] result,
  output logic            exdone,
  output logic            busy
);

  localparam int unsigned CNT_W = (XLEN == RV_XLEN) ? MUL_CNT_W : $clog2(XLEN);
  localparam int unsigned AW    = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  // Returns {sign, magnitude}. The magnitude of the most negative value wraps
  // back to itself, which is exactly 2^(XLEN-1) read as unsigned.
  function automatic logic [XLEN:0] sign_mag(input logic [XLEN-1:0] v,
                                             input logic            treat_signed);
    logic neg;
    neg = treat_signed & v[XLEN-1];
    return {neg, (neg ? (~v) + XLEN'(1) : v)};
  endfunction

  mul_state_e       state_reg, state_next;
  mulctl_e          ctl_reg, ctl_next;
  logic [XLEN-1:0]  mag_a_reg, mag_a_next;
  logic [XLEN-1:0]  mag_b_reg, mag_b_next;
  logic             neg_reg, neg_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [AW-1:0]    acc_reg, acc_next;
  logic [XLEN-1:0]  result_reg, result_next;
  logic             exdone_reg, exdone_next;

  logic [XLEN:0]    sm_a, sm_b;
  logic [XLEN-1:0]  mag_b_shift;
  logic [AW-1:0]    acc_add;
  logic [AW-1:0]    product;
  logic             last_bit;
  logic             take_req;
  mulctl_e          req_ctl;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= MST_IDLE;
      ctl_reg    <= MULCTL_MUL;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      neg_reg    <= 1'b0;
      count_reg  <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      exdone_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ctl_reg    <= ctl_next;
      mag_a_reg  <= mag_a_next;
      mag_b_reg  <= mag_b_next;
      neg_reg    <= neg_next;
      count_reg  <= count_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      exdone_reg <= exdone_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    ctl_next    = ctl_reg;
    mag_a_next  = mag_a_reg;
    mag_b_next  = mag_b_reg;
    neg_next    = neg_reg;
    count_next  = count_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    exdone_next = 1'b0;
    take_req    = 1'b0;

    req_ctl     = mulctl_e'(mulctl);
    sm_a        = sign_mag(rs1_val, a_is_signed(req_ctl));
    sm_b        = sign_mag(rs2_val, b_is_signed(req_ctl));

    mag_b_shift = mag_b_reg >> 1;
    acc_add     = AW'(mag_a_reg) << count_reg;
    // Two's-complement negate of the full-width accumulator (modulo 2^AW).
    product     = neg_reg ? (~acc_reg) + AW'(1) : acc_reg;

`ifdef MUL_EARLY_OUT_EN
    // Leave as soon as the bit being consumed now is the last set one.
    last_bit = (count_reg == LAST_CNT) || (mag_b_shift == '0);
`else
    last_bit = (count_reg == LAST_CNT);
`endif

    unique case (state_reg)
      MST_IDLE: begin
        take_req = mulstart;
      end

      MST_BUSY: begin
        if (mag_b_reg[0]) begin
          acc_next = acc_reg + acc_add;
        end
        mag_b_next = mag_b_shift;
        count_next = count_reg + CNT_W'(1);
        if (last_bit) begin
          state_next = MST_FIN;
        end
      end

      MST_FIN: begin
        exdone_next = 1'b1;
        result_next = (ctl_reg == MULCTL_MUL) ? product[XLEN-1:0]
                                              : product[AW-1:XLEN];
        state_next  = MST_IDLE;
        // Back-to-back: a request seen here starts the next multiply directly.
        take_req    = mulstart;
      end

      default: begin
        state_next = MST_IDLE;
      end
    endcase

    if (take_req) begin
      state_next = MST_BUSY;
      ctl_next   = req_ctl;
      mag_a_next = sm_a[XLEN-1:0];
      mag_b_next = sm_b[XLEN-1:0];
      neg_next   = sm_a[XLEN] ^ sm_b[XLEN];
      count_next = '0;
      acc_next   = '0;
    end
  end

  assign result = result_reg;
  assign exdone = exdone_reg;
  assign busy   = (state_reg == MST_BUSY) || (state_reg == MST_FIN);

endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit
//   Directed and randomised checks of mul_unit (XLEN = 32). Expected latency
//   follows the build: with MUL_EARLY_OUT_EN it depends on |b|, otherwise 33.
// -----------------------------------------------------------------------------
module tb_mul_unit;

  localparam int XLEN = 32;

`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            mulstart;
  logic [1:0]      mulctl;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] result;
  logic            exdone;
  logic            busy;

  int n_vec;
  int n_err;

  mul_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mulstart (mulstart),
    .mulctl   (mulctl),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .result   (result),
    .exdone   (exdone),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: sign/zero-extend to 64 bits and multiply modulo 2^64.
  function automatic logic [31:0] ref_mul(input logic [1:0] ctl,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (ctl != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = ((ctl == 2'b00 || ctl == 2'b01) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = ea * eb;
    return (ctl == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycles from the mulstart edge to the cycle exdone is seen high.
  function automatic int exp_lat(input logic [1:0] ctl, input logic [31:0] b);
    logic [31:0] mb;
    int h;
    mb = ((ctl == 2'b00 || ctl == 2'b01) && b[31]) ? (~b) + 32'd1 : b;
    h  = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) h = i;
    return EARLY ? 2 + h : 33;
  endfunction

  // Issue one request and wait for exdone. lat = -1 on timeout.
  task automatic run_op(input logic [1:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic [31:0] res, output bit busy_drop);
    @(negedge clk);
    mulctl = ctl; rs1_val = a; rs2_val = b; mulstart = 1'b1;
    @(posedge clk); #1;
    mulstart = 1'b0;
    rs1_val = $urandom; rs2_val = $urandom;
    lat = 0; busy_drop = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (exdone) break;
      if (!busy) busy_drop = 1'b1;
      if (lat >= 100) begin lat = -1; break; end
    end
    res = result;
    $display("op ctl=%0d a=%h b=%h -> result=%h latency=%0d", ctl, a, b, res, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mulstart = 1'b0; mulctl = 2'b00; rs1_val = '0; rs2_val = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h want=%h", result, 32'h0); end
    n_vec++; if (exdone !== 1'b0)  begin n_err++; $display("FAIL reset_exdone got=%b want=0", exdone); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_mul_basic();
    int lat; logic [31:0] res; bit bd;
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, lat, res, bd);
    n_vec++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_7x-3 got=%h want=%h", res, 32'hFFFF_FFEB); end
    n_vec++; if (lat != exp_lat(2'b00, 32'hFFFF_FFFD)) begin n_err++; $display("FAIL mul_latency got=%0d want=%0d", lat, exp_lat(2'b00, 32'hFFFF_FFFD)); end
    n_vec++; if (bd) begin n_err++; $display("FAIL mul_busy got=dropped want=held"); end
    @(posedge clk); #1;
    n_vec++; if (exdone !== 1'b0) begin n_err++; $display("FAIL exdone_single got=%b want=0", exdone); end
    n_vec++; if (result !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL result_hold got=%h want=%h", result, 32'hFFFF_FFEB); end
  endtask

  task automatic test_high_halves();
    int lat; logic [31:0] res; bit bd;
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, res, bd);
    n_vec++; if (res !== 32'h4000_0000) begin n_err++; $display("FAIL mulh_min got=%h want=%h", res, 32'h4000_0000); end
    run_op(2'b11, 32'h8000_0000, 32'h8000_0000, lat, res, bd);
    n_vec++; if (res !== 32'h4000_0000) begin n_err++; $display("FAIL mulhu_min got=%h want=%h", res, 32'h4000_0000); end
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bd);
    n_vec++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu_ones got=%h want=%h", res, 32'hFFFF_FFFF); end
    n_vec++; if (lat != exp_lat(2'b10, 32'hFFFF_FFFF)) begin n_err++; $display("FAIL mulhsu_latency got=%0d want=%0d", lat, exp_lat(2'b10, 32'hFFFF_FFFF)); end
  endtask

  task automatic test_back_to_back();
    int lat;
    // First op: MULHU 3 x 0x80000001 = 0x1_80000003 -> 1, 33 cycles in both builds.
    @(negedge clk);
    mulctl = 2'b11; rs1_val = 32'd3; rs2_val = 32'h8000_0001; mulstart = 1'b1;
    @(posedge clk); #1;
    mulstart = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    // Now in the FIN cycle of the first op.
    n_vec++; if (exdone !== 1'b0) begin n_err++; $display("FAIL b2b_early_exdone got=%b want=0", exdone); end
    mulctl = 2'b00; rs1_val = 32'd5; rs2_val = 32'd6; mulstart = 1'b1;
    @(posedge clk); #1;
    mulstart = 1'b0; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678;
    n_vec++; if (exdone !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got=%b want=1", exdone); end
    n_vec++; if (result !== 32'd1) begin n_err++; $display("FAIL b2b_first_result got=%h want=%h", result, 32'd1); end
    $display("op ctl=3 a=00000003 b=80000001 -> result=%h (back-to-back first)", result);
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (exdone) break;
      if (lat >= 100) begin lat = -1; break; end
    end
    $display("op ctl=0 a=00000005 b=00000006 -> result=%h latency=%0d", result, lat);
    n_vec++; if (lat != exp_lat(2'b00, 32'd6)) begin n_err++; $display("FAIL b2b_latency got=%0d want=%0d", lat, exp_lat(2'b00, 32'd6)); end
    n_vec++; if (result !== 32'd30) begin n_err++; $display("FAIL b2b_5x6 got=%h want=%h", result, 32'd30); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    mulctl = 2'b00; rs1_val = 32'd1000; rs2_val = 32'hFFFF_FC18; mulstart = 1'b1;
    @(posedge clk); #1;
    mulstart = 1'b0;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (exdone) break;
      if (lat >= 100) begin lat = -1; break; end
      mulstart = (lat == 2 || lat == 5);
      mulctl   = 2'b11;
      rs1_val  = $urandom;
      rs2_val  = $urandom;
    end
    mulstart = 1'b0;
    $display("op ctl=0 a=000003e8 b=fffffc18 -> result=%h latency=%0d (noisy inputs)", result, lat);
    n_vec++; if (result !== 32'hFFF0_BDC0) begin n_err++; $display("FAIL busy_ignore_result got=%h want=%h", result, 32'hFFF0_BDC0); end
    n_vec++; if (lat != exp_lat(2'b00, 32'hFFFF_FC18)) begin n_err++; $display("FAIL busy_ignore_latency got=%0d want=%0d", lat, exp_lat(2'b00, 32'hFFFF_FC18)); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_ignore_restart got=%b want=0", busy); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] res; bit bd;
    @(negedge clk);
    mulctl = 2'b11; rs1_val = 32'd3; rs2_val = 32'h8000_0001; mulstart = 1'b1;
    @(posedge clk); #1;
    mulstart = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    n_vec++; if (result !== 32'hFFF0_BDC0) begin n_err++; $display("FAIL pre_reset_hold got=%h want=%h", result, 32'hFFF0_BDC0); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL async_reset_result got=%h want=%h", result, 32'h0); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL async_reset_busy got=%b want=0", busy); end
    n_vec++; if (exdone !== 1'b0)  begin n_err++; $display("FAIL async_reset_exdone got=%b want=0", exdone); end
    $display("reset asserted mid-busy");
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, res, bd);
    n_vec++; if (res !== 32'h3FFF_FFFF) begin n_err++; $display("FAIL post_reset_mulh got=%h want=%h", res, 32'h3FFF_FFFF); end
    n_vec++; if (lat != exp_lat(2'b01, 32'h7FFF_FFFF)) begin n_err++; $display("FAIL post_reset_latency got=%0d want=%0d", lat, exp_lat(2'b01, 32'h7FFF_FFFF)); end
  endtask

  task automatic test_early_out();
    int lat; logic [31:0] res; bit bd;
    run_op(2'b11, 32'hFFFF_FFFF, 32'd1, lat, res, bd);
    n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL eo_mulhu_x1 got=%h want=%h", res, 32'h0); end
    n_vec++; if (lat != (EARLY ? 2 : 33)) begin n_err++; $display("FAIL eo_mulhu_latency got=%0d want=%0d", lat, (EARLY ? 2 : 33)); end
    run_op(2'b00, 32'h0000_1234, 32'd0, lat, res, bd);
    n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL eo_mul_x0 got=%h want=%h", res, 32'h0); end
    n_vec++; if (lat != (EARLY ? 2 : 33)) begin n_err++; $display("FAIL eo_zero_latency got=%0d want=%0d", lat, (EARLY ? 2 : 33)); end
    run_op(2'b01, 32'h0001_0000, 32'hFFFF_FFFF, lat, res, bd);
    n_vec++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL eo_mulh_neg1 got=%h want=%h", res, 32'hFFFF_FFFF); end
    n_vec++; if (lat != (EARLY ? 2 : 33)) begin n_err++; $display("FAIL eo_neg1_latency got=%0d want=%0d", lat, (EARLY ? 2 : 33)); end
  endtask

  task automatic test_sweep();
    int lat; logic [31:0] res, a, b, want; logic [1:0] ctl; bit bd;
    for (int i = 0; i < 300; i++) begin
      ctl = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 10 == 1) a = 32'h8000_0000;
      if (i % 10 == 2) b = 32'h8000_0000;
      if (i % 10 == 3) b = 32'($urandom_range(0, 255));
      want = ref_mul(ctl, a, b);
      run_op(ctl, a, b, lat, res, bd);
      n_vec++; if (res !== want) begin n_err++; $display("FAIL sweep_result[%0d] got=%h want=%h", i, res, want); end
      n_vec++; if (lat != exp_lat(ctl, b)) begin n_err++; $display("FAIL sweep_latency[%0d] got=%0d want=%0d", i, lat, exp_lat(ctl, b)); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_mul_basic();
    test_high_halves();
    test_back_to_back();
    test_busy_ignore();
    test_async_reset();
    test_early_out();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
